axil_reg_slave: RTL and testbench

- AXI4-Lite responder (slave end of the AXI4-Lite interface) for the test-app testbench path.
- Terminates AXI4-Lite write and read transactions from the host driver and converts each one into a single request/response transaction on a simple register bus.
- Sits between the driver-side AXI4-Lite interface and the CGRA global-controller / configuration register file.
- Handles one transaction at a time, arbitrates reads against writes, checks alignment, and generates BRESP/RRESP.

---
 rtl/axil_pkg.sv | 19 +
 rtl/axil_slot.sv | 37 +++
 rtl/axil_reg_slave.sv | 201 ++++++++++++++++++++
 tb/tb_axil_reg_slave.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite register-bus responder.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    // Read data returned when the register target never answers.
    localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/axil_slot.sv
// Single-entry holding register with a valid/ready input side.
// The slot accepts one beat when enabled and empty, and holds it until cleared.
module axil_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    output logic         o_full,
    output logic [W-1:0] o_data
);

    logic         r_full;
    logic [W-1:0] r_data;

    assign o_ready = ~r_full & i_en;
    assign o_full  = r_full;
    assign o_data  = r_data;

    // Capture a beat on handshake; a clear empties the slot for the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_clr) begin
            r_full <= 1'b0;
        end else if (i_valid && o_ready) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite responder that turns each AXI read or write into one
// request/response exchange on a simple register bus.
// Optional build macro AXIL_REG_SLAVE_TIMEOUT_EN adds a response timeout
// of TIMEOUT_CYCLES cycles in WAIT; without it WAIT holds indefinitely.
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH     = 13,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]              awprot,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [2:0]              arprot,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    output logic                    req_valid,
    output logic                    req_write,
    output logic [ADDR_WIDTH-1:0]   req_addr,
    output logic [DATA_WIDTH-1:0]   req_wdata,
    output logic [DATA_WIDTH/8-1:0] req_wstrb,
    input  logic                    rsp_valid,
    input  logic [DATA_WIDTH-1:0]   rsp_rdata,
    input  logic                    rsp_err
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int WSLOT_W  = DATA_WIDTH + STRB_W;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_alive;
    logic                    r_is_write;
    logic                    r_rr_rd;
    resp_t                   r_resp;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_req_write;
    logic [ADDR_WIDTH-1:0]   r_req_addr;
    logic [DATA_WIDTH-1:0]   r_req_wdata;
    logic [STRB_W-1:0]       r_req_wstrb;

    logic                    w_aw_full, w_w_full, w_ar_full;
    logic                    w_aw_en, w_ar_en, w_aw_clr, w_ar_clr;
    logic [ADDR_WIDTH-1:0]   w_aw_addr, w_ar_addr, w_gaddr;
    logic [WSLOT_W-1:0]      w_wslot;
    logic                    w_wr_pend, w_rd_pend, w_grant, w_grant_wr;
    logic                    w_misalign, w_rsp_take, w_done, w_tmo;
    logic                    w_unused_prot;

    assign w_unused_prot = ^{awprot, arprot};

    // Readies only open in IDLE, and never during or right after reset.
    assign w_aw_en = r_alive & (r_state == IDLE);
    assign w_ar_en = w_aw_en & ~(w_aw_full & w_w_full);

    axil_slot #(.W(ADDR_WIDTH)) u_aw_slot (
        .clk(clk), .rst_n(rst_n), .i_valid(awvalid), .i_en(w_aw_en), .i_clr(w_aw_clr),
        .i_data(awaddr), .o_ready(awready), .o_full(w_aw_full), .o_data(w_aw_addr)
    );

    axil_slot #(.W(WSLOT_W)) u_w_slot (
        .clk(clk), .rst_n(rst_n), .i_valid(wvalid), .i_en(w_aw_en), .i_clr(w_aw_clr),
        .i_data({wstrb, wdata}), .o_ready(wready), .o_full(w_w_full), .o_data(w_wslot)
    );

    axil_slot #(.W(ADDR_WIDTH)) u_ar_slot (
        .clk(clk), .rst_n(rst_n), .i_valid(arvalid), .i_en(w_ar_en), .i_clr(w_ar_clr),
        .i_data(araddr), .o_ready(arready), .o_full(w_ar_full), .o_data(w_ar_addr)
    );

    // Round-robin: r_rr_rd set means a read wins a simultaneous request.
    assign w_wr_pend  = w_aw_full & w_w_full;
    assign w_rd_pend  = w_ar_full;
    assign w_grant    = (r_state == IDLE) & (w_wr_pend | w_rd_pend);
    assign w_grant_wr = w_wr_pend & (~w_rd_pend | ~r_rr_rd);
    assign w_gaddr    = w_grant_wr ? w_aw_addr : w_ar_addr;
    assign w_misalign = |w_gaddr[ADDR_LSB-1:0];
    assign w_rsp_take = (r_state == WAIT) & rsp_valid;
    assign w_done     = (r_state == RESP) & (r_is_write ? bready : rready);
    assign w_aw_clr   = w_done & r_is_write;
    assign w_ar_clr   = w_done & ~r_is_write;

`ifdef AXIL_REG_SLAVE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    // Count cycles spent waiting on the target, restarting at every issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_tmo_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_tmo = (r_state == WAIT) & ~rsp_valid &
                   (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    localparam logic [31:0] TMO_CFG = TIMEOUT_CYCLES;
    logic w_unused_tmo;
    assign w_unused_tmo = ^TMO_CFG;
    assign w_tmo        = 1'b0;
`endif

    // Out-of-reset marker that keeps the readies low while reset is applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_alive <= 1'b0;
        else        r_alive <= 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs; misaligned grants skip the register bus.
    always_comb begin
        w_state_nxt = r_state;
        req_valid   = 1'b0;
        bvalid      = 1'b0;
        rvalid      = 1'b0;
        case (r_state)
            IDLE:  if (w_grant) w_state_nxt = w_misalign ? RESP : ISSUE;
            ISSUE: begin
                req_valid   = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT:  if (w_rsp_take || w_tmo) w_state_nxt = RESP;
            RESP: begin
                bvalid = r_is_write;
                rvalid = ~r_is_write;
                if (w_done) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Transaction context: request fields at grant, response at completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_write  <= 1'b0;
            r_rr_rd     <= 1'b1;
            r_resp      <= OKAY;
            r_rdata     <= '0;
            r_req_write <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_wstrb <= '0;
        end else begin
            if (w_grant) begin
                r_is_write <= w_grant_wr;
                r_rr_rd    <= w_grant_wr;
                if (w_misalign) begin
                    r_resp  <= SLVERR;
                    r_rdata <= '0;
                end else begin
                    r_req_write <= w_grant_wr;
                    r_req_addr  <= w_gaddr;
                    r_req_wdata <= w_grant_wr ? w_wslot[DATA_WIDTH-1:0] : '0;
                    r_req_wstrb <= w_grant_wr ? w_wslot[WSLOT_W-1:DATA_WIDTH] : '0;
                end
            end
            if (w_rsp_take) begin
                r_resp <= rsp_err ? SLVERR : OKAY;
                if (!r_is_write) r_rdata <= rsp_rdata;
            end else if (w_tmo) begin
                r_resp <= SLVERR;
                if (!r_is_write) r_rdata <= {(DATA_WIDTH / 32){DEADBEEF}};
            end
        end
    end

    assign bresp     = r_resp;
    assign rresp     = r_resp;
    assign rdata     = r_rdata;
    assign req_write = r_req_write;
    assign req_addr  = r_req_addr;
    assign req_wdata = r_req_wdata;
    assign req_wstrb = r_req_wstrb;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave: directed vector table, hand-written
// corner sequences and a randomized phase against a word-memory model.
module tb_axil_reg_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] awaddr, araddr, req_addr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata, req_wdata, rsp_rdata;
    logic [3:0]  wstrb, req_wstrb;
    logic [1:0]  bresp, rresp;
    logic        req_valid, req_write, rsp_valid, rsp_err;

    axil_reg_slave #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Register-bus target (environment) and the bench's own expectation memory.
    logic [31:0] tgt_mem [0:2047];
    logic [31:0] ref_mem [0:2047];
    int          req_cnt = 0;
    bit          req_hist[$];
    logic [12:0] last_addr;
    logic        last_write;
    logic [31:0] last_wdata;
    logic [3:0]  last_wstrb;
    bit          tgt_silent = 1'b0;
    bit          tgt_err = 1'b0;
    int          tgt_lat = 1;
    int          spur_n = 0;
    int          spur_seen = 0;

    typedef struct {
        bit          wr;
        logic [12:0] addr;
        logic [31:0] wd;
        logic [3:0]  ws;
        bit          err;
        int          order;   // 0: AW first, 1: W first, 2: same cycle
        int          dly;     // cycles B/R ready is held low
        logic [1:0]  eresp;
        logic [31:0] erd;
        bit          ereq;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic void ref_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[a[12:2]][8*b +: 8] = d[8*b +: 8];
    endfunction

    // Target: answers each request after tgt_lat cycles unless silenced.
    initial begin
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (req_valid === 1'b1) begin
                req_cnt++;
                req_hist.push_back(req_write);
                last_addr  = req_addr;
                last_write = req_write;
                last_wdata = req_wdata;
                last_wstrb = req_wstrb;
                if (!tgt_silent) begin
                    repeat (tgt_lat) @(negedge clk);
                    rsp_err   = tgt_err;
                    rsp_rdata = tgt_mem[last_addr[12:2]];
                    if (last_write && !tgt_err)
                        for (int b = 0; b < 4; b++)
                            if (last_wstrb[b]) tgt_mem[last_addr[12:2]][8*b +: 8] = last_wdata[8*b +: 8];
                    rsp_valid = 1'b1;
                    @(negedge clk);
                    rsp_valid = 1'b0;
                    rsp_err   = 1'b0;
                    rsp_rdata = $urandom;
                end
            end else if (spur_seen != spur_n) begin
                spur_seen = spur_n;
                rsp_valid = 1'b1;
                rsp_rdata = 32'hBAD0_BAD0;
                @(negedge clk);
                rsp_valid = 1'b0;
            end
        end
    end

    task automatic addr_phase(input bit do_aw, input bit do_w, input bit do_ar,
                              input int aw_dly, input int w_dly,
                              input logic [12:0] aw_a, input logic [31:0] wd,
                              input logic [3:0] ws, input logic [12:0] ar_a);
        bit aw_d, w_d, ar_d, h_aw, h_w, h_ar;
        int t;
        aw_d = !do_aw; w_d = !do_w; ar_d = !do_ar; t = 0;
        awaddr = aw_a; wdata = wd; wstrb = ws; araddr = ar_a;
        while (!(aw_d && w_d && ar_d) && t < 100) begin
            awvalid = !aw_d && (t >= aw_dly);
            wvalid  = !w_d && (t >= w_dly);
            arvalid = !ar_d;
            #1;
            h_aw = awvalid && awready;
            h_w  = wvalid && wready;
            h_ar = arvalid && arready;
            @(negedge clk);
            if (h_aw) aw_d = 1'b1;
            if (h_w)  w_d  = 1'b1;
            if (h_ar) ar_d = 1'b1;
            t++;
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("addr handshake", 32'(aw_d && w_d && ar_d), 32'd1);
    endtask

    task automatic resp_phase(input bit wr, input int dly, input string tag,
                              output logic [1:0] r, output logic [31:0] d);
        int t = 0;
        while (((wr ? bvalid : rvalid) !== 1'b1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " resp seen"}, 32'(wr ? bvalid : rvalid), 32'd1);
        r = wr ? bresp : rresp;
        d = rdata;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk({tag, " valid hold"}, 32'(wr ? bvalid : rvalid), 32'd1);
            chk({tag, " resp hold"}, 32'(wr ? bresp : rresp), 32'(r));
            if (wr) chk({tag, " awready during B"}, 32'(awready), 32'd0);
            else    chk({tag, " rdata hold"}, rdata, d);
        end
        if (wr) bready = 1'b1; else rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        chk({tag, " valid drop"}, 32'(wr ? bvalid : rvalid), 32'd0);
    endtask

    task automatic do_txn(input bit wr, input logic [12:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input bit err, input int order,
                          input int dly, input int lat, input logic [1:0] eresp,
                          input logic [31:0] erd, input bit ereq, input string tag);
        int          rc0;
        logic [1:0]  r;
        logic [31:0] d;
        tgt_err = err; tgt_lat = lat; rc0 = req_cnt;
        if (wr) addr_phase(1, 1, 0, (order == 1) ? 2 : 0, (order == 0) ? 2 : 0, a, wd, ws, 13'h0);
        else    addr_phase(0, 0, 1, 0, 0, 13'h0, 32'h0, 4'h0, a);
        resp_phase(wr, dly, tag, r, d);
        chk({tag, " resp"}, 32'(r), 32'(eresp));
        if (!wr) chk({tag, " rdata"}, d, erd);
        chk({tag, " req count"}, 32'(req_cnt - rc0), 32'(ereq));
        if (ereq && (req_cnt - rc0) == 1) begin
            chk({tag, " req addr"}, 32'(last_addr), 32'(a));
            chk({tag, " req write"}, 32'(last_write), 32'(wr));
            if (wr) begin
                chk({tag, " req wdata"}, last_wdata, wd);
                chk({tag, " req wstrb"}, 32'(last_wstrb), 32'(ws));
            end
        end
        tgt_err = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        int          n0, t;
        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arprot = '0; arvalid = 0; rready = 0;
        for (int i = 0; i < 2048; i++) begin
            tgt_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        tgt_mem[13'h040 >> 2] = 32'h1234_5678;
        ref_mem[13'h040 >> 2] = 32'h1234_5678;

        tbl[0]  = '{1, 13'h010, 32'hA5A5_0001, 4'hF, 0, 0, 0, 2'b00, 32'h0, 1};
        tbl[1]  = '{1, 13'h014, 32'h1122_3344, 4'hF, 0, 1, 5, 2'b00, 32'h0, 1};
        tbl[2]  = '{0, 13'h010, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'hA5A5_0001, 1};
        tbl[3]  = '{1, 13'h020, 32'hFFFF_1111, 4'h3, 0, 2, 1, 2'b00, 32'h0, 1};
        tbl[4]  = '{0, 13'h020, 32'h0,         4'h0, 0, 0, 2, 2'b00, 32'h0000_1111, 1};
        tbl[5]  = '{0, 13'h013, 32'h0,         4'h0, 0, 0, 0, 2'b10, 32'h0, 0};
        tbl[6]  = '{1, 13'h022, 32'h5555_AAAA, 4'hF, 0, 0, 0, 2'b10, 32'h0, 0};
        tbl[7]  = '{1, 13'h030, 32'hCAFE_F00D, 4'hF, 1, 0, 0, 2'b10, 32'h0, 1};
        tbl[8]  = '{0, 13'h030, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'h0, 1};
        tbl[9]  = '{0, 13'h014, 32'h0,         4'h0, 1, 0, 0, 2'b10, 32'h1122_3344, 1};
        tbl[10] = '{1, 13'h1FFC, 32'hBEEF_0000, 4'hC, 0, 2, 0, 2'b00, 32'h0, 1};
        tbl[11] = '{0, 13'h1FFC, 32'h0,        4'h0, 0, 0, 3, 2'b00, 32'hBEEF_0000, 1};

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst awready", 32'(awready), 0);
        chk("rst wready", 32'(wready), 0);
        chk("rst arready", 32'(arready), 0);
        chk("rst bvalid", 32'(bvalid), 0);
        chk("rst rvalid", 32'(rvalid), 0);
        chk("rst req_valid", 32'(req_valid), 0);
        chk("rst resp", 32'({bresp, rresp}), 0);
        chk("rst rdata", rdata, 0);
        chk("rst req_addr", 32'(req_addr), 0);
        chk("rst req_wdata", req_wdata, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle awready", 32'(awready), 1);
        chk("idle arready", 32'(arready), 1);

        // Simultaneous read and write right after reset: read goes first.
        n0 = req_hist.size();
        tgt_lat = 1;
        addr_phase(1, 1, 1, 0, 0, 13'h044, 32'hDDCC_0001, 4'hF, 13'h040);
        resp_phase(0, 0, "rw read", r, d);
        chk("rw rresp", 32'(r), 0);
        chk("rw rdata", d, 32'h1234_5678);
        resp_phase(1, 0, "rw write", r, d);
        chk("rw bresp", 32'(r), 0);
        chk("rw req count", 32'(req_hist.size() - n0), 2);
        if (req_hist.size() - n0 == 2) begin
            chk("rw first is read", 32'(req_hist[n0]), 0);
            chk("rw second is write", 32'(req_hist[n0+1]), 1);
        end
        ref_write(13'h044, 32'hDDCC_0001, 4'hF);

        // Stray target strobe while idle must not produce a response.
        spur_n++;
        repeat (3) @(negedge clk);
        chk("stray bvalid", 32'(bvalid), 0);
        chk("stray rvalid", 32'(rvalid), 0);

        // Directed vectors.
        for (int i = 0; i < 12; i++) begin
            do_txn(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].ws, tbl[i].err, tbl[i].order,
                   tbl[i].dly, 1, tbl[i].eresp, tbl[i].erd, tbl[i].ereq, $sformatf("vec%0d", i));
            if (tbl[i].wr && tbl[i].addr[1:0] == 2'b00 && !tbl[i].err)
                ref_write(tbl[i].addr, tbl[i].wd, tbl[i].ws);
        end

        // Reset while waiting on a silent target abandons the transaction.
        tgt_silent = 1'b1;
        addr_phase(0, 0, 1, 0, 0, 13'h0, 32'h0, 4'h0, 13'h010);
        t = 0;
        while (req_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rstwait req seen", 32'(req_valid), 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst awready", 32'(awready), 0);
        chk("async rst wready", 32'(wready), 0);
        chk("async rst arready", 32'(arready), 0);
        chk("async rst valids", 32'({bvalid, rvalid, req_valid}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tgt_silent = 1'b0;
        repeat (3) @(negedge clk);
        chk("post rst rvalid", 32'(rvalid), 0);
        do_txn(0, 13'h010, 32'h0, 4'h0, 0, 0, 0, 1, 2'b00, 32'hA5A5_0001, 1, "post rst read");

`ifdef AXIL_REG_SLAVE_TIMEOUT_EN
        // Silent target: SLVERR with DEADBEEF 8 cycles after entering WAIT.
        tgt_silent = 1'b1;
        addr_phase(0, 0, 1, 0, 0, 13'h0, 32'h0, 4'h0, 13'h010);
        t = 0;
        while (req_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("tmo req seen", 32'(req_valid), 1);
        t = 0;
        while (rvalid !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("tmo latency", 32'(t), 9);
        chk("tmo rresp", 32'(rresp), 32'h2);
        chk("tmo rdata", rdata, 32'hDEAD_BEEF);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        tgt_silent = 1'b0;
        repeat (6) @(negedge clk);
`endif

        // Randomized traffic against the word-memory model.
        for (int n = 0; n < 40; n++) begin
            bit          wr, err, mis;
            logic [12:0] a;
            logic [31:0] wd;
            logic [3:0]  ws;
            wr  = 1'($urandom_range(0, 1));
            a   = 13'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            wd  = $urandom;
            ws  = 4'($urandom_range(0, 15));
            err = ($urandom_range(0, 7) == 0);
            mis = (a[1:0] != 2'b00);
            do_txn(wr, a, wd, ws, err, $urandom_range(0, 2), $urandom_range(0, 3),
                   $urandom_range(1, 4), (mis || err) ? 2'b10 : 2'b00,
                   mis ? 32'h0 : ref_mem[a[12:2]], !mis, $sformatf("rnd%0d", n));
            if (wr && !mis && !err) ref_write(a, wd, ws);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
